// File: rtl/dft_pkg.sv
// Shared constants and helpers for the DFT accumulation / power stages.
// Holds FSM state codes, default widths and the power-width helper.
package dft_pkg;

    localparam int DFT_ACCUM_WIDTH = 18;
    localparam int DFT_NUM_BINS    = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_OUT  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    function automatic int pwr_width(input int aw);
        return 2 * aw + 1;
    endfunction

endpackage

// File: rtl/dft_power_peak_search_cplx_mag_sq.sv
// cplx_mag_sq: registered |x|^2 = re^2 + im^2 of one complex sample.
// Ports: clk_i, rst_i (async high), en_i (load), re_i, im_i, pwr_o.
module cplx_mag_sq
    import dft_pkg::*;
#(
    parameter int  ACCUM_WIDTH = DFT_ACCUM_WIDTH,
    localparam int POWER_WIDTH = pwr_width(ACCUM_WIDTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic signed [ACCUM_WIDTH-1:0] re_i,
    input  logic signed [ACCUM_WIDTH-1:0] im_i,
    output logic [POWER_WIDTH-1:0]        pwr_o
);

    localparam int PW2 = 2 * ACCUM_WIDTH;

    logic signed [PW2-1:0] re_x;
    logic signed [PW2-1:0] im_x;
    logic signed [PW2-1:0] sq_re;
    logic signed [PW2-1:0] sq_im;
    logic [POWER_WIDTH-1:0] pwr_d;
    logic [POWER_WIDTH-1:0] pwr_q;

    // Squares are computed at 2*AW bits, wide enough that the most
    // negative input (-2^(AW-1)) squares exactly without overflow.
    assign re_x  = {{ACCUM_WIDTH{re_i[ACCUM_WIDTH-1]}}, re_i};
    assign im_x  = {{ACCUM_WIDTH{im_i[ACCUM_WIDTH-1]}}, im_i};
    assign sq_re = re_x * re_x;
    assign sq_im = im_x * im_x;
    assign pwr_d = {1'b0, sq_re} + {1'b0, sq_im};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwr_q <= '0;
        end else if (en_i) begin
            pwr_q <= pwr_d;
        end
    end

    assign pwr_o = pwr_q;

endmodule

// File: rtl/dft_power_peak_search.sv
// Snapshots NUM_BINS complex accumulators, streams per-bin power
// over valid/ready and reports the peak bin once per frame.
// Ports: clk_i, rst_i (async high), A_real_i/A_imag_i (packed bins,
// bin k at [k*AW +: AW]), valid_i, busy_o, overrun_o, pwr_valid_o,
// pwr_ready_i, pwr_o, pwr_bin_o, pwr_last_o, peak_valid_o,
// peak_bin_o, peak_pwr_o.
// Optional: DFT_PWR_THRESHOLD_EN adds thresh_i and peak_hit_o.
module dft_power_peak_search
    import dft_pkg::*;
#(
    parameter int  ACCUM_WIDTH   = DFT_ACCUM_WIDTH,
    parameter int  NUM_BINS      = DFT_NUM_BINS,
    localparam int BIN_IDX_WIDTH = $clog2(NUM_BINS),
    localparam int POWER_WIDTH   = pwr_width(ACCUM_WIDTH)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_BINS*ACCUM_WIDTH-1:0] A_real_i,
    input  logic [NUM_BINS*ACCUM_WIDTH-1:0] A_imag_i,
    input  logic                            valid_i,
`ifdef DFT_PWR_THRESHOLD_EN
    input  logic [POWER_WIDTH-1:0]          thresh_i,
    output logic                            peak_hit_o,
`endif
    output logic                            busy_o,
    output logic                            overrun_o,
    output logic                            pwr_valid_o,
    input  logic                            pwr_ready_i,
    output logic [POWER_WIDTH-1:0]          pwr_o,
    output logic [BIN_IDX_WIDTH-1:0]        pwr_bin_o,
    output logic                            pwr_last_o,
    output logic                            peak_valid_o,
    output logic [BIN_IDX_WIDTH-1:0]        peak_bin_o,
    output logic [POWER_WIDTH-1:0]          peak_pwr_o
);

    localparam int SW = NUM_BINS * ACCUM_WIDTH;
    localparam logic [BIN_IDX_WIDTH-1:0] LAST_BIN =
        BIN_IDX_WIDTH'(NUM_BINS - 1);

    state_t                   state_q, state_d;
    logic [BIN_IDX_WIDTH-1:0] bin_cnt_q, bin_cnt_d;
    logic [SW-1:0]            snap_re_q, snap_im_q;
    logic [BIN_IDX_WIDTH-1:0] run_bin_q, run_bin_d;
    logic [POWER_WIDTH-1:0]   run_pwr_q, run_pwr_d;
    logic [BIN_IDX_WIDTH-1:0] peak_bin_q, peak_bin_d;
    logic [POWER_WIDTH-1:0]   peak_pwr_q, peak_pwr_d;
    logic                     overrun_q;
    logic                     snap_load;
    logic                     mag_en;
    logic                     is_last;
    logic [POWER_WIDTH-1:0]   mag_pwr;
    logic [ACCUM_WIDTH-1:0]   sel_re, sel_im;
`ifdef DFT_PWR_THRESHOLD_EN
    logic [POWER_WIDTH-1:0]   thresh_q, thresh_d;
    logic                     hit_q, hit_d;
`endif

    assign sel_re  = snap_re_q[bin_cnt_q*ACCUM_WIDTH +: ACCUM_WIDTH];
    assign sel_im  = snap_im_q[bin_cnt_q*ACCUM_WIDTH +: ACCUM_WIDTH];
    assign is_last = (bin_cnt_q == LAST_BIN);

    cplx_mag_sq #(
        .ACCUM_WIDTH(ACCUM_WIDTH)
    ) u_mag (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (mag_en),
        .re_i  (sel_re),
        .im_i  (sel_im),
        .pwr_o (mag_pwr)
    );

    always_comb begin
        state_d    = state_q;
        bin_cnt_d  = bin_cnt_q;
        run_bin_d  = run_bin_q;
        run_pwr_d  = run_pwr_q;
        peak_bin_d = peak_bin_q;
        peak_pwr_d = peak_pwr_q;
        snap_load  = 1'b0;
        mag_en     = 1'b0;
`ifdef DFT_PWR_THRESHOLD_EN
        thresh_d   = thresh_q;
        hit_d      = hit_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    snap_load = 1'b1;
                    bin_cnt_d = '0;
                    run_bin_d = '0;
                    run_pwr_d = '0;
`ifdef DFT_PWR_THRESHOLD_EN
                    thresh_d  = thresh_i;
`endif
                    state_d   = ST_MUL;
                end
            end
            ST_MUL: begin
                mag_en  = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (pwr_ready_i) begin
                    // Strict compare keeps the lowest index on ties.
                    if (bin_cnt_q == '0 || mag_pwr > run_pwr_q) begin
                        run_bin_d = bin_cnt_q;
                        run_pwr_d = mag_pwr;
                    end
                    if (is_last) begin
                        // Peak outputs land together with the DONE pulse.
                        peak_bin_d = run_bin_d;
                        peak_pwr_d = run_pwr_d;
`ifdef DFT_PWR_THRESHOLD_EN
                        hit_d      = (run_pwr_d >= thresh_q);
`endif
                        state_d    = ST_DONE;
                    end else begin
                        bin_cnt_d = bin_cnt_q + BIN_IDX_WIDTH'(1);
                        state_d   = ST_MUL;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            bin_cnt_q  <= '0;
            snap_re_q  <= '0;
            snap_im_q  <= '0;
            run_bin_q  <= '0;
            run_pwr_q  <= '0;
            peak_bin_q <= '0;
            peak_pwr_q <= '0;
            overrun_q  <= 1'b0;
`ifdef DFT_PWR_THRESHOLD_EN
            thresh_q   <= '0;
            hit_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bin_cnt_q  <= bin_cnt_d;
            run_bin_q  <= run_bin_d;
            run_pwr_q  <= run_pwr_d;
            peak_bin_q <= peak_bin_d;
            peak_pwr_q <= peak_pwr_d;
            overrun_q  <= valid_i && (state_q != ST_IDLE);
            if (snap_load) begin
                snap_re_q <= A_real_i;
                snap_im_q <= A_imag_i;
            end
`ifdef DFT_PWR_THRESHOLD_EN
            thresh_q   <= thresh_d;
            hit_q      <= hit_d;
`endif
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign overrun_o    = overrun_q;
    assign pwr_valid_o  = (state_q == ST_OUT);
    assign pwr_o        = mag_pwr;
    assign pwr_bin_o    = bin_cnt_q;
    assign pwr_last_o   = (state_q == ST_OUT) && is_last;
    assign peak_valid_o = (state_q == ST_DONE);
    assign peak_bin_o   = peak_bin_q;
    assign peak_pwr_o   = peak_pwr_q;
`ifdef DFT_PWR_THRESHOLD_EN
    assign peak_hit_o   = hit_q;
`endif

endmodule

// File: tb/tb_dft_power_peak_search.sv
// Scoreboard bench for dft_power_peak_search.
// Frames are modelled per bin; a monitor pops and compares outputs.
module tb_dft_power_peak_search;

    localparam int AW = 18;
    localparam int NB = 16;
    localparam int BW = 4;
    localparam int PW = 37;

    typedef struct {
        int     bin;
        longint pwr;
        bit     last;
    } pwr_exp_t;

    typedef struct {
        int     bin;
        longint pwr;
        bit     hit;
    } peak_exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NB*AW-1:0]  a_re = '0;
    logic [NB*AW-1:0]  a_im = '0;
    logic              valid = 1'b0;
    logic              busy, overrun;
    logic              pwr_valid;
    logic              pwr_ready = 1'b1;
    logic [PW-1:0]     pwr;
    logic [BW-1:0]     pwr_bin;
    logic              pwr_last;
    logic              peak_valid;
    logic [BW-1:0]     peak_bin;
    logic [PW-1:0]     peak_pwr;
`ifdef DFT_PWR_THRESHOLD_EN
    logic [PW-1:0]     thresh = '0;
    logic              peak_hit;
`endif

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;
    int re_a[NB];
    int im_a[NB];

    pwr_exp_t  pwr_q[$];
    peak_exp_t peak_q[$];

    bit            hold_v = 0;
    logic [PW-1:0] hold_pwr;
    logic [BW-1:0] hold_bin;
    logic          hold_last;

    dft_power_peak_search dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .A_real_i     (a_re),
        .A_imag_i     (a_im),
        .valid_i      (valid),
`ifdef DFT_PWR_THRESHOLD_EN
        .thresh_i     (thresh),
        .peak_hit_o   (peak_hit),
`endif
        .busy_o       (busy),
        .overrun_o    (overrun),
        .pwr_valid_o  (pwr_valid),
        .pwr_ready_i  (pwr_ready),
        .pwr_o        (pwr),
        .pwr_bin_o    (pwr_bin),
        .pwr_last_o   (pwr_last),
        .peak_valid_o (peak_valid),
        .peak_bin_o   (peak_bin),
        .peak_pwr_o   (peak_pwr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: power per bin and peak from plain arithmetic.
    task automatic send_frame(input longint thr);
        longint p, best;
        int     bbin;
        best = -1;
        bbin = 0;
        for (int k = 0; k < NB; k++) begin
            logic [AW-1:0] r, i;
            r = AW'(re_a[k]);
            i = AW'(im_a[k]);
            a_re[k*AW +: AW] = r;
            a_im[k*AW +: AW] = i;
            p = longint'(re_a[k]) * re_a[k] + longint'(im_a[k]) * im_a[k];
            pwr_q.push_back('{bin: k, pwr: p, last: (k == NB - 1)});
            if (p > best) begin
                best = p;
                bbin = k;
            end
        end
        peak_q.push_back('{bin: bbin, pwr: best, hit: (best >= thr)});
        @(posedge clk);
        #1;
`ifdef DFT_PWR_THRESHOLD_EN
        thresh = PW'(thr);
`endif
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_peak(output int first, output int pk);
        int n;
        n = 0;
        first = -1;
        pk = -1;
        while (n < 600) begin
            @(negedge clk);
            n++;
            if (pwr_valid && first < 0) first = n;
            if (peak_valid) begin
                pk = n;
                break;
            end
        end
        if (pk < 0) begin
            failures++;
            $display("FAIL peak_timeout: no peak_valid within %0d cycles", n);
        end
    endtask

    task automatic wait_bin(input int b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pwr_valid && pwr_bin == BW'(b)) && n < 200);
        if (n >= 200) begin
            failures++;
            $display("FAIL bin_timeout: bin %0d never presented", b);
        end
    endtask

    task automatic ramp_frame();
        for (int k = 0; k < NB; k++) begin
            re_a[k] = k;
            im_a[k] = 0;
        end
        re_a[5] = 100;
        im_a[5] = -100;
    endtask

    task automatic rand_frame(input int lim);
        for (int k = 0; k < NB; k++) begin
            re_a[k] = $urandom_range(0, 2 * lim) - lim;
            im_a[k] = $urandom_range(0, 2 * lim) - lim;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: pwr_ready = 1'b1;
                1: pwr_ready = 1'($urandom_range(0, 1));
                default: pwr_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks handshakes, peak pulses and held values.
    initial begin
        pwr_exp_t  e;
        peak_exp_t q;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 0;
            end else begin
                if (pwr_valid) begin
                    if (hold_v) begin
                        chk("hold_pwr", pwr, hold_pwr);
                        chk("hold_bin", pwr_bin, hold_bin);
                        chk("hold_last", pwr_last, hold_last);
                    end
                    if (pwr_ready) begin
                        hold_v = 0;
                        if (pwr_q.size() == 0) begin
                            failures++;
                            $display("FAIL pwr_unexpected: bin %0d", pwr_bin);
                        end else begin
                            e = pwr_q.pop_front();
                            chk("pwr", pwr, e.pwr);
                            chk("pwr_bin", pwr_bin, e.bin);
                            chk("pwr_last", pwr_last, e.last);
                        end
                    end else begin
                        hold_v = 1;
                        hold_pwr = pwr;
                        hold_bin = pwr_bin;
                        hold_last = pwr_last;
                    end
                end else if (hold_v) begin
                    failures++;
                    $display("FAIL valid_drop: got 0 expected 1");
                    hold_v = 0;
                end
                if (peak_valid) begin
                    if (peak_q.size() == 0) begin
                        failures++;
                        $display("FAIL peak_unexpected: bin %0d", peak_bin);
                    end else begin
                        q = peak_q.pop_front();
                        chk("peak_bin", peak_bin, q.bin);
                        chk("peak_pwr", peak_pwr, q.pwr);
`ifdef DFT_PWR_THRESHOLD_EN
                        chk("peak_hit", peak_hit, q.hit);
`endif
                    end
                end
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, pk, cnt;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_pwr_valid", pwr_valid, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_pwr", pwr, 0);
        chk("rst_peak_pwr", peak_pwr, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Ramp frame, ready high: latency and frame time.
        ramp_frame();
        send_frame(20000);
        wait_peak(first, pk);
        chk("lat_first_pwr", first, 2);
        chk("lat_peak", pk, 33);
        @(negedge clk);
        chk("peak_pulse_one", peak_valid, 0);
        chk("peak_bin_held", peak_bin, 5);

        ramp_frame();
        send_frame(20001);
        wait_peak(first, pk);

        // Ties: lowest index wins.
        for (int k = 0; k < NB; k++) begin
            re_a[k] = 3;
            im_a[k] = 4;
        end
        send_frame(0);
        wait_peak(first, pk);

        // Extremes: most negative input squares exactly.
        for (int k = 0; k < NB; k++) begin
            re_a[k] = -131072;
            im_a[k] = -131072;
        end
        re_a[9] = 131071;
        im_a[9] = 0;
        send_frame(0);
        wait_peak(first, pk);

        // Backpressure: hold bin 3 for 5 cycles.
        rand_frame(131071);
        send_frame(0);
        wait_bin(2);
        rdy_mode = 2;
        wait_bin(3);
        repeat (5) @(negedge clk);
        chk("bp_bin", pwr_bin, 3);
        chk("bp_valid", pwr_valid, 1);
        rdy_mode = 0;
        wait_peak(first, pk);

        // Random frames with random ready; small range forces ties.
        rdy_mode = 1;
        for (int f = 0; f < 4; f++) begin
            rand_frame((f % 2 == 0) ? 3 : 131071);
            send_frame(longint'($urandom_range(0, 40)));
            wait_peak(first, pk);
        end
        rdy_mode = 0;

        // Overrun during bin 7: frame keeps original data.
        rand_frame(2000);
        send_frame(0);
        wait_bin(7);
        @(posedge clk);
        #1;
        a_re = ~a_re;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("overrun_pulse", overrun, 1);
        @(negedge clk);
        chk("overrun_single", overrun, 0);
        wait_peak(first, pk);

        // Reset mid-frame at bin 7.
        rand_frame(2000);
        send_frame(0);
        wait_bin(7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        pwr_q.delete();
        peak_q.delete();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pwr_valid", pwr_valid, 0);
        chk("mid_rst_pwr", pwr, 0);
        chk("mid_rst_pwr_bin", pwr_bin, 0);
        chk("mid_rst_peak_bin", peak_bin, 0);
        chk("mid_rst_peak_pwr", peak_pwr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (peak_valid || pwr_valid) cnt++;
        end
        chk("no_peak_after_rst", cnt, 0);

        ramp_frame();
        send_frame(20000);
        wait_peak(first, pk);
        chk("post_rst_lat", pk, 33);

        repeat (4) @(negedge clk);
        chk("pwr_q_empty", pwr_q.size(), 0);
        chk("peak_q_empty", peak_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
